// File: rtl/p18_handshake_tx_pkg.sv
// Shared definitions for the p18 outbound handshake: state encoding and a
// width helper for the internal counters.
package p18_handshake_tx_pkg;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_SETUP  = 2'd1;
    localparam logic [1:0] ENC_REQ_HI = 2'd2;
    localparam logic [1:0] ENC_REQ_LO = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_SETUP  = ENC_SETUP,
        ST_REQ_HI = ENC_REQ_HI,
        ST_REQ_LO = ENC_REQ_LO
    } tx_state_t;

    // ceil(log2(value)), never less than 1 so a counter always has a bit
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/p18_synchronizer.sv
// Two-flop synchronizer for signals arriving from outside the clk domain.
module p18_synchronizer #(
    parameter int unsigned      WIDTH         = 1,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            meta     <= DEFAULT_VALUE;
            sync_out <= DEFAULT_VALUE;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/p18_handshake_tx.sv
// Initiator side of a 4-phase req/ack handshake towards an asynchronous
// receiver; ext_ack is resynchronized before the FSM looks at it.
//  state     | meaning
//  ST_IDLE   | waiting for a word; blocked while the receiver still holds ack
//  ST_SETUP  | ext_data driven, counting setup time before raising req
//  ST_REQ_HI | ext_req high, waiting for ack to rise (or phase timeout)
//  ST_REQ_LO | ext_req low, waiting for ack to fall (or phase timeout)
module p18_handshake_tx
    import p18_handshake_tx_pkg::*;
#(
    parameter int unsigned      WIDTH          = 8,
    parameter int unsigned      SETUP_CYCLES   = 2,
    parameter int unsigned      TIMEOUT_CYCLES = 1024,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE  = '0
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_done,
    output logic             tx_timeout,
    output logic [WIDTH-1:0] ext_data,
    output logic             ext_req,
    input  logic             ext_ack
);

    localparam int unsigned       SETUP_W    = clog2_min1(SETUP_CYCLES);
    localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'(SETUP_CYCLES - 1);
    localparam int unsigned       TO_W       = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam int unsigned       TO_LOAD_I  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TO_W-1:0]    TO_LOAD    = TO_W'(TO_LOAD_I);
    localparam bit                TO_EN      = (TIMEOUT_CYCLES > 0);

    tx_state_t          state;
    tx_state_t          state_nxt;
    logic               ack_s;
    logic               accept;
    logic               load_data;
    logic               req_nxt;
    logic               done_nxt;
    logic               tout_nxt;
    logic               phase_expired;
    logic [SETUP_W-1:0] setup_cnt;
    logic [SETUP_W-1:0] setup_cnt_nxt;
    logic [TO_W-1:0]    phase_cnt;
    logic [TO_W-1:0]    phase_cnt_nxt;

    p18_synchronizer #(
        .WIDTH         (1),
        .DEFAULT_VALUE (1'b0)
    ) u_ack_sync (
        .clk      (clk),
        .nRst     (nRst),
        .async_in (ext_ack),
        .sync_out (ack_s)
    );

    assign tx_ready      = (state == ST_IDLE) && !ack_s;
    assign accept        = tx_valid && tx_ready;
    assign phase_expired = TO_EN && (phase_cnt == '0);

    // Phase counters are down-counters loaded on entry; terminal count at zero.
    always_comb begin
        state_nxt     = state;
        req_nxt       = ext_req;
        done_nxt      = 1'b0;
        tout_nxt      = 1'b0;
        load_data     = 1'b0;
        setup_cnt_nxt = setup_cnt;
        phase_cnt_nxt = phase_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load_data     = 1'b1;
                    setup_cnt_nxt = SETUP_LOAD;
                    state_nxt     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_cnt == '0) begin
                    req_nxt       = 1'b1;
                    phase_cnt_nxt = TO_LOAD;
                    state_nxt     = ST_REQ_HI;
                end else begin
                    setup_cnt_nxt = setup_cnt - 1'b1;
                end
            end
            ST_REQ_HI: begin
                if (ack_s) begin
                    req_nxt       = 1'b0;
                    phase_cnt_nxt = TO_LOAD;
                    state_nxt     = ST_REQ_LO;
                end else if (phase_expired) begin
                    req_nxt   = 1'b0;
                    tout_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (TO_EN) begin
                    phase_cnt_nxt = phase_cnt - 1'b1;
                end
            end
            ST_REQ_LO: begin
                if (!ack_s) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (phase_expired) begin
                    req_nxt   = 1'b0;
                    tout_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (TO_EN) begin
                    phase_cnt_nxt = phase_cnt - 1'b1;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= ST_IDLE;
            ext_data   <= DEFAULT_VALUE;
            ext_req    <= 1'b0;
            tx_done    <= 1'b0;
            tx_timeout <= 1'b0;
            setup_cnt  <= '0;
            phase_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            ext_req    <= req_nxt;
            tx_done    <= done_nxt;
            tx_timeout <= tout_nxt;
            setup_cnt  <= setup_cnt_nxt;
            phase_cnt  <= phase_cnt_nxt;
            if (load_data) begin
                ext_data <= tx_data;
            end
        end
    end

endmodule

// File: tb/tb_p18_handshake_tx.sv
// Directed bench for p18_handshake_tx: one instance with the default timeout,
// a second with a 16-cycle timeout for the abort scenario.
module tb_p18_handshake_tx;

    logic       clk;
    logic       nRst;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_timeout;
    logic [7:0] ext_data;
    logic       ext_req;
    logic       ext_ack;

    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic       tx_done2;
    logic       tx_timeout2;
    logic [7:0] ext_data2;
    logic       ext_req2;
    logic       ext_ack2;

    int n_vec;
    int n_err;
    logic [7:0] exp_q[$];
    logic [7:0] word;
    logic [7:0] exp_word;

    p18_handshake_tx #(
        .WIDTH          (8),
        .SETUP_CYCLES   (2),
        .TIMEOUT_CYCLES (1024),
        .DEFAULT_VALUE  (8'h00)
    ) u_dut (
        .clk        (clk),
        .nRst       (nRst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_timeout (tx_timeout),
        .ext_data   (ext_data),
        .ext_req    (ext_req),
        .ext_ack    (ext_ack)
    );

    p18_handshake_tx #(
        .WIDTH          (8),
        .SETUP_CYCLES   (2),
        .TIMEOUT_CYCLES (16),
        .DEFAULT_VALUE  (8'h00)
    ) u_dut_to (
        .clk        (clk),
        .nRst       (nRst),
        .tx_data    (tx_data2),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready2),
        .tx_done    (tx_done2),
        .tx_timeout (tx_timeout2),
        .ext_data   (ext_data2),
        .ext_req    (ext_req2),
        .ext_ack    (ext_ack2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        nRst      = 1'b0;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        ext_ack   = 1'b0;
        tx_data2  = 8'h00;
        tx_valid2 = 1'b0;
        ext_ack2  = 1'b0;

        // reset values
        tick(2);
        check("rst_req",   ext_req,    1'b0);
        check("rst_data",  ext_data,   8'h00);
        check("rst_done",  tx_done,    1'b0);
        check("rst_tout",  tx_timeout, 1'b0);
        check("rst_ready", tx_ready,   1'b1);
        nRst = 1'b1;
        tick(1);

        // basic handshake, A5
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        check("b_ready0", tx_ready, 1'b1);
        tick(1);
        tx_valid = 1'b0;
        check("b_data_T",  ext_data, 8'hA5);
        check("b_req_T",   ext_req,  1'b0);
        check("b_ready_T", tx_ready, 1'b0);
        tick(1);
        check("b_req_T1", ext_req, 1'b0);
        tick(1);
        check("b_req_T2", ext_req, 1'b1);
        tick(3);
        check("b_req_wait", ext_req, 1'b1);
        ext_ack = 1'b1;
        tick(2);
        check("b_req_ack2", ext_req, 1'b1);
        // ack_s is high after two edges; the FSM drops req on the edge that samples it
        tick(1);
        check("b_req_fall", ext_req, 1'b0);
        check("b_done_early", tx_done, 1'b0);
        ext_ack = 1'b0;
        tick(2);
        check("b_done_wait",  tx_done,  1'b0);
        check("b_ready_wait", tx_ready, 1'b0);
        tick(1);
        check("b_done",       tx_done,  1'b1);
        check("b_ready_done", tx_ready, 1'b1);
        check("b_data_hold",  ext_data, 8'hA5);
        tick(1);
        check("b_done_pulse", tx_done,  1'b0);
        check("b_ready_next", tx_ready, 1'b1);

        // back-to-back with tx_valid held
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        tick(1);
        check("bb_data1", ext_data, 8'h01);
        tx_data = 8'h02;
        tick(2);
        check("bb_req1",   ext_req,  1'b1);
        check("bb_ready1", tx_ready, 1'b0);
        check("bb_hold1",  ext_data, 8'h01);
        ext_ack = 1'b1;
        tick(3);
        check("bb_reqlo1", ext_req,  1'b0);
        check("bb_hold2",  ext_data, 8'h01);
        ext_ack = 1'b0;
        tick(2);
        check("bb_hold3", ext_data, 8'h01);
        tick(1);
        check("bb_done1",  tx_done,  1'b1);
        check("bb_hold4",  ext_data, 8'h01);
        tick(1);
        check("bb_data2",   ext_data, 8'h02);
        check("bb_ready2",  tx_ready, 1'b0);
        tx_valid = 1'b0;
        tick(2);
        check("bb_req2", ext_req, 1'b1);
        ext_ack = 1'b1;
        tick(3);
        check("bb_reqlo2", ext_req, 1'b0);
        ext_ack = 1'b0;
        tick(3);
        check("bb_done2", tx_done, 1'b1);
        tick(1);

        // timeout on the 16-cycle instance, receiver never acks
        tx_data2  = 8'h3C;
        tx_valid2 = 1'b1;
        tick(1);
        tx_valid2 = 1'b0;
        tick(2);
        check("to_req_rise", ext_req2, 1'b1);
        tick(15);
        check("to_req_15",  ext_req2,    1'b1);
        check("to_tout_15", tx_timeout2, 1'b0);
        tick(1);
        check("to_req_16",   ext_req2,    1'b0);
        check("to_tout",     tx_timeout2, 1'b1);
        check("to_nodone",   tx_done2,    1'b0);
        check("to_ready",    tx_ready2,   1'b1);
        tick(1);
        check("to_tout_pulse", tx_timeout2, 1'b0);
        check("to_nodone2",    tx_done2,    1'b0);

        // stuck ack in IDLE
        ext_ack = 1'b1;
        tick(2);
        check("sa_ready0", tx_ready, 1'b0);
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        tick(3);
        check("sa_ready1", tx_ready, 1'b0);
        check("sa_data",   ext_data, 8'h02);
        check("sa_req",    ext_req,  1'b0);
        ext_ack  = 1'b0;
        tx_valid = 1'b0;
        tick(1);
        check("sa_ready_e1", tx_ready, 1'b0);
        tick(1);
        check("sa_ready_e2", tx_ready, 1'b1);
        check("sa_data2",    ext_data, 8'h02);

        // reset in the middle of REQ_HI with ack rising
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(2);
        check("rm_req", ext_req, 1'b1);
        ext_ack = 1'b1;
        tick(1);
        #2;
        nRst = 1'b0;
        #1;
        check("rm_req_async",  ext_req,    1'b0);
        check("rm_data_async", ext_data,   8'h00);
        check("rm_done",       tx_done,    1'b0);
        check("rm_tout",       tx_timeout, 1'b0);
        tick(1);
        nRst = 1'b1;
        tick(2);
        check("rm_ready_ack", tx_ready, 1'b0);
        ext_ack = 1'b0;
        tick(2);
        check("rm_ready", tx_ready, 1'b1);
        check("rm_done2", tx_done,  1'b0);

        // random receiver delays, scoreboard on ack rise
        for (int w = 0; w < 200; w++) begin
            for (int k = 0; k < 50 && tx_ready !== 1'b1; k++) tick(1);
            check("rd_ready", tx_ready, 1'b1);
            word     = 8'($urandom);
            tx_data  = word;
            tx_valid = 1'b1;
            exp_q.push_back(word);
            tick(1);
            tx_valid = 1'b0;
            tx_data  = ~word;
            for (int k = 0; k < 50 && ext_req !== 1'b1; k++) tick(1);
            check("rd_req_hi", ext_req, 1'b1);
            tick($urandom_range(0, 20));
            exp_word = exp_q.pop_front();
            check("rd_word", ext_data, exp_word);
            ext_ack = 1'b1;
            for (int k = 0; k < 50 && ext_req !== 1'b0; k++) tick(1);
            check("rd_req_lo", ext_req, 1'b0);
            tick($urandom_range(0, 20));
            ext_ack = 1'b0;
            for (int k = 0; k < 50 && tx_done !== 1'b1; k++) tick(1);
            check("rd_done", tx_done, 1'b1);
        end
        check("rd_no_tout", tx_timeout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
